// File: rtl/bandpass_fir_pkg.sv
// Shared constants and the half-coefficient table for the fs/4 band-pass FIR.
// The table holds h[0..15]; the filter is symmetric so h[30-n] == h[n].
package bandpass_fir_pkg;

    localparam int COEF_W     = 16;
    localparam int FRAC_SHIFT = 15;
    localparam int ACC_W      = 16 + COEF_W + 5;

    function automatic logic signed [COEF_W-1:0] half_coef(input int idx);
        logic signed [COEF_W-1:0] c;
        case (idx)
            15:      c = 16'sd16384;
            13:      c = -16'sd10560;
            11:      c = 16'sd3072;
            9:       c = -16'sd1024;
            7:       c = 16'sd512;
            5:       c = -16'sd256;
            3:       c = 16'sd128;
            1:       c = -16'sd64;
            default: c = 16'sd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bpf_preadd_mult.sv
// Registered signed (a + b) * coef for one symmetric tap pair of the band-pass FIR.
module bpf_preadd_mult
    import bandpass_fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CW     = COEF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [CW-1:0]        coef,
    output logic [DATA_W+CW:0]   prod
);

    localparam int PROD_W = DATA_W + CW + 1;

    logic signed [DATA_W:0]   sum_s;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [PROD_W-1:0] prod_q;

    // Pre-add with one guard bit, then multiply by the pair coefficient
    always_comb begin
        sum_s  = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        prod_d = PROD_W'(sum_s) * PROD_W'($signed(coef));
    end

    // Product register
    always_ff @(posedge clk) begin
        if (!rst) begin
            prod_q <= {PROD_W{1'b0}};
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod = prod_q;

endmodule

// File: rtl/bandpass_fir.sv
// Streaming 31-tap linear-phase band-pass FIR centred at fs/4 with DC and Nyquist nulls.
// Pipeline: delay line -> pair products -> accumulate -> round/saturate; three cycles input to output.
module bandpass_fir
    import bandpass_fir_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TAP_CNT = 31,
    parameter int GAIN_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     valid_out,
    output logic [DATA_W+GAIN_W-1:0] data_out
);

    localparam int OUT_W  = DATA_W + GAIN_W;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = ACC_W + DATA_W - 16;
    localparam int N_MULT = 8;

    localparam logic signed [SUM_W-1:0] ROUND_BIAS = SUM_W'(32'sd1) <<< (FRAC_SHIFT - 1);
    localparam logic signed [SUM_W-1:0] OUT_MAX    = (SUM_W'(32'sd1) <<< (OUT_W - 1)) - SUM_W'(32'sd1);
    localparam logic signed [SUM_W-1:0] OUT_MIN    = -(SUM_W'(32'sd1) <<< (OUT_W - 1));

    generate
        if (TAP_CNT != 31) begin : g_tap_check
            $error("bandpass_fir: coefficient table is fixed, only TAP_CNT=31 is supported");
        end
    endgenerate

    logic [DATA_W-1:0]       x_q [TAP_CNT];
    logic [DATA_W-1:0]       x_d [TAP_CNT];
    logic [2:0]              vld_q;
    logic [2:0]              vld_d;
    logic [PROD_W-1:0]       prod_s [N_MULT];
    logic signed [SUM_W-1:0] acc_d;
    logic signed [SUM_W-1:0] acc_q;
    logic signed [SUM_W-1:0] rnd_s;
    logic [OUT_W-1:0]        sat_s;
    logic                    valid_out_d;
    logic                    valid_out_q;
    logic [OUT_W-1:0]        data_out_d;
    logic [OUT_W-1:0]        data_out_q;

    // Delay-line shift on accepted samples and valid history
    always_comb begin
        x_d = x_q;
        if (valid_in) begin
            x_d[0] = data_in;
            for (int k = 1; k < TAP_CNT; k++) begin
                x_d[k] = x_q[k-1];
            end
        end else begin
            x_d = x_q;
        end
        vld_d = {vld_q[1:0], valid_in};
    end

    // Delay line and valid pipeline registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < TAP_CNT; k++) begin
                x_q[k] <= {DATA_W{1'b0}};
            end
            vld_q <= 3'b000;
        end else begin
            x_q   <= x_d;
            vld_q <= vld_d;
        end
    end

    // Only odd taps are nonzero; the centre tap has no mirror partner
    for (genvar p = 0; p < N_MULT; p++) begin : g_pair
        localparam int N = 2 * p + 1;
        logic [DATA_W-1:0] mirror_s;
        if (N == TAP_CNT / 2) begin : g_centre
            assign mirror_s = {DATA_W{1'b0}};
        end else begin : g_side
            assign mirror_s = x_q[TAP_CNT-1-N];
        end
        bpf_preadd_mult #(
            .DATA_W (DATA_W),
            .CW     (COEF_W)
        ) u_pm (
            .clk  (clk),
            .rst  (rst),
            .a    (x_q[N]),
            .b    (mirror_s),
            .coef (half_coef(N)),
            .prod (prod_s[p])
        );
    end

    // Full-precision sum of the pair products
    always_comb begin
        acc_d = {SUM_W{1'b0}};
        for (int i = 0; i < N_MULT; i++) begin
            acc_d = acc_d + SUM_W'($signed(prod_s[i]));
        end
    end

    // Round half up, saturate, and update the output only for valid results
    always_comb begin
        rnd_s = (acc_q + ROUND_BIAS) >>> FRAC_SHIFT;
        if (rnd_s > OUT_MAX) begin
            sat_s = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (rnd_s < OUT_MIN) begin
            sat_s = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_s = rnd_s[OUT_W-1:0];
        end
        valid_out_d = vld_q[2];
        if (vld_q[2]) begin
            data_out_d = sat_s;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Accumulator and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q       <= {SUM_W{1'b0}};
            valid_out_q <= 1'b0;
            data_out_q  <= {OUT_W{1'b0}};
        end else begin
            acc_q       <= acc_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_bandpass_fir.sv
// Self-checking bench for bandpass_fir: direct-convolution reference model plus hand-computed pins.
module tb_bandpass_fir;

    localparam int DW = 16;
    localparam int OW = 20;

    typedef int line_t [31];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid_in = 1'b1;
    logic [DW-1:0] data_in = 16'd1234;
    logic          valid_out;
    logic [OW-1:0] data_out;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    logic last_vo;
    int cap[$];

    const int h [31] = '{0, -64, 0, 128, 0, -256, 0, 512, 0, -1024, 0, 3072, 0, -10560, 0, 16384,
                         0, -10560, 0, 3072, 0, -1024, 0, 512, 0, -256, 0, 128, 0, -64, 0};
    const int imp_exp [31] = '{0, -32, 0, 64, 0, -128, 0, 256, 0, -512, 0, 1536, 0, -5280, 0, 8192,
                               0, -5280, 0, 1536, 0, -512, 0, 256, 0, -128, 0, 64, 0, -32, 0};

    bandpass_fir dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    function automatic line_t shifted(input line_t xs, input int d);
        line_t r;
        r[0] = d;
        for (int k = 1; k < 31; k++) r[k] = xs[k-1];
        return r;
    endfunction

    function automatic int model_y(input line_t xs);
        longint acc = 0;
        for (int k = 0; k < 31; k++) acc += longint'(h[k]) * longint'(xs[k]);
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 64'sd524287) acc = 64'sd524287;
        else if (acc < -64'sd524288) acc = -64'sd524288;
        return int'(acc);
    endfunction

    // Reference model: delay line of accepted samples, results emerge three edges later
    line_t    mx = '{default: 0};
    logic [2:0] mv = 3'b000;
    int       my [3] = '{default: 0};
    logic     exp_valid = 1'b0;
    int       exp_data = 0;

    always @(posedge clk) begin
        if (!rst) begin
            mx        <= '{default: 0};
            mv        <= 3'b000;
            my        <= '{default: 0};
            exp_valid <= 1'b0;
            exp_data  <= 0;
        end else begin
            if (valid_in) mx <= shifted(mx, int'($signed(data_in)));
            mv        <= {mv[1:0], valid_in};
            my[0]     <= model_y(shifted(mx, int'($signed(data_in))));
            my[1]     <= my[0];
            my[2]     <= my[1];
            exp_valid <= mv[2];
            if (mv[2]) exp_data <= my[2];
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: compare outputs against the model, then apply the next inputs
    task automatic drive(input logic r, input logic v, input int d);
        @(negedge clk);
        if (armed) begin
            checks++;
            if (valid_out !== exp_valid || data_out !== OW'(exp_data)) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t: valid_out=%b data_out=%0d expected valid_out=%b data_out=%0d",
                         $time, valid_out, $signed(data_out), exp_valid, exp_data);
            end
        end
        last_vo = valid_out;
        if (valid_out === 1'b1) cap.push_back(int'($signed(data_out)));
        rst      = r;
        valid_in = v;
        data_in  = DW'(d);
    endtask

    task automatic restart();
        drive(1'b0, 1'b0, 0);
        cap.delete();
    endtask

    task automatic drain();
        repeat (6) drive(1'b1, 1'b0, 0);
    endtask

    initial begin
        int first;
        int j;
        int c;
        int peak;
        int a;

        @(posedge clk);
        armed = 1'b1;
        drive(1'b0, 1'b1, 1234);
        drive(1'b0, 1'b1, 1234);
        check_int("reset_valid_out_zero", (valid_out === 1'b0) ? 0 : 1, 0);
        check_int("reset_data_out_zero", (data_out === 20'd0) ? 0 : 1, 0);

        // Impulse with latency pin
        restart();
        drive(1'b1, 1'b1, 16384);
        first = -1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 1'b1, 0);
            if (first < 0 && last_vo === 1'b1) first = i;
        end
        drain();
        check_int("impulse_latency", first, 3);
        check_int("impulse_count", cap.size(), 31);
        if (cap.size() == 31)
            for (int i = 0; i < 31; i++) check_int($sformatf("impulse_y%0d", i), cap[i], imp_exp[i]);

        // Gapped impulse: every third cycle idle, with junk on data_in
        restart();
        j = 0;
        c = 0;
        while (j < 31) begin
            if (c % 3 == 2) drive(1'b1, 1'b0, 777);
            else begin
                drive(1'b1, 1'b1, (j == 0) ? 16384 : 0);
                j++;
            end
            c++;
        end
        drain();
        check_int("gapped_count", cap.size(), 31);
        if (cap.size() == 31)
            for (int i = 0; i < 31; i += 5) check_int($sformatf("gapped_y%0d", i), cap[i], imp_exp[i]);

        // DC null
        restart();
        repeat (40) drive(1'b1, 1'b1, 1000);
        drain();
        check_int("dc_count", cap.size(), 40);
        if (cap.size() == 40) check_int("dc_settled", cap[39], 0);

        // Nyquist null
        restart();
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, (i % 2 == 0) ? 20000 : -20000);
        drain();
        if (cap.size() == 40) check_int("nyquist_settled", cap[39], 0);
        else check_int("nyquist_count", cap.size(), 40);

        // fs/4 tone passband peak
        restart();
        for (int i = 0; i < 48; i++) drive(1'b1, 1'b1, (i % 4 == 1) ? 16384 : ((i % 4 == 3) ? -16384 : 0));
        drain();
        peak = 0;
        for (int i = 30; i < cap.size(); i++) begin
            a = (cap[i] < 0) ? -cap[i] : cap[i];
            if (a > peak) peak = a;
        end
        check_int("tone_peak", peak, 23808);

        // Most negative input at the centre tap
        restart();
        drive(1'b1, 1'b1, -32768);
        repeat (15) drive(1'b1, 1'b1, 0);
        drain();
        check_int("extreme_count", cap.size(), 16);
        if (cap.size() == 16) check_int("extreme_centre", cap[15], -16384);

        // Reset mid-stream discards in-flight samples
        restart();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 100 * (i + 1));
        drive(1'b0, 1'b1, 999);
        drain();
        check_int("midreset_outputs", cap.size(), 2);

        // Random stream with gaps and full-scale values
        restart();
        for (int i = 0; i < 300; i++) begin
            int d;
            case ($urandom_range(0, 7))
                0:       d = -32768;
                1:       d = 32767;
                default: d = int'($signed(16'($urandom_range(0, 65535))));
            endcase
            drive(1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, d);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
